// File: rtl/alu_pkg.sv
// Shared opcode constants and FSM state encoding for the iterative ALU.
package alu_pkg;

  localparam logic [3:0] OP_AND   = 4'b0000;
  localparam logic [3:0] OP_OR    = 4'b0001;
  localparam logic [3:0] OP_ADD   = 4'b0010;
  localparam logic [3:0] OP_XOR   = 4'b0011;
  localparam logic [3:0] OP_NOR   = 4'b0100;
  localparam logic [3:0] OP_SLTU  = 4'b0101;
  localparam logic [3:0] OP_SUB   = 4'b0110;
  localparam logic [3:0] OP_SLT   = 4'b0111;
  localparam logic [3:0] OP_SLL   = 4'b1000;
  localparam logic [3:0] OP_SRL   = 4'b1001;
  localparam logic [3:0] OP_SRA   = 4'b1010;
  localparam logic [3:0] OP_MULTU = 4'b1100;
  localparam logic [3:0] OP_DIVU  = 4'b1101;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ITER = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/alu_muldiv.sv
// Iterative unsigned multiply (shift-add) and divide (restoring), one bit per
// cycle. A start pulse loads the operands; exactly WIDTH steps follow. done is
// asserted during the final step and lo/hi present that step's result, so the
// caller registers the answer on the same edge the engine finishes.
module alu_muldiv
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             op_div,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             done,
  output logic [WIDTH-1:0] lo,
  output logic [WIDTH-1:0] hi
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  logic             busy;
  logic [CW-1:0]    cnt;
  logic             div_mode;
  logic [WIDTH-1:0] acc;      // product high half / partial remainder
  logic [WIDTH-1:0] sreg;     // multiplier shifting out / dividend-to-quotient
  logic [WIDTH-1:0] opnd;     // multiplicand / divisor
  logic [WIDTH:0]   mul_sum;
  logic [WIDTH:0]   div_shift;
  logic [WIDTH:0]   div_diff;
  logic [WIDTH-1:0] acc_nx;
  logic [WIDTH-1:0] sreg_nx;

  // One iteration step of whichever operation is loaded.
  always_comb begin
    mul_sum   = sreg[0] ? ({1'b0, acc} + {1'b0, opnd}) : {1'b0, acc};
    div_shift = {acc, sreg[WIDTH-1]};
    div_diff  = div_shift - {1'b0, opnd};
    acc_nx    = acc;
    sreg_nx   = sreg;
    if (div_mode) begin
      // A borrow out of the top bit means the trial subtraction went negative.
      if (div_diff[WIDTH]) begin
        acc_nx  = div_shift[WIDTH-1:0];
        sreg_nx = {sreg[WIDTH-2:0], 1'b0};
      end else begin
        acc_nx  = div_diff[WIDTH-1:0];
        sreg_nx = {sreg[WIDTH-2:0], 1'b1};
      end
    end else begin
      acc_nx  = mul_sum[WIDTH:1];
      sreg_nx = {mul_sum[0], sreg[WIDTH-1:1]};
    end
  end

  assign done = busy && (cnt == CNT_LAST);
  assign lo   = sreg_nx;
  assign hi   = acc_nx;

  // Control: busy flag and iteration counter, cleared by reset to abort.
  always_ff @(posedge clk) begin
    if (reset) begin
      busy <= 1'b0;
      cnt  <= '0;
    end else if (start) begin
      busy <= 1'b1;
      cnt  <= '0;
    end else if (busy) begin
      cnt <= cnt + 1'b1;
      if (done) busy <= 1'b0;
    end
  end

  // Datapath: operand load on start, one step per busy cycle.
  always_ff @(posedge clk) begin
    if (start) begin
      acc      <= '0;
      sreg     <= a;
      opnd     <= b;
      div_mode <= op_div;
    end else if (busy) begin
      acc  <= acc_nx;
      sreg <= sreg_nx;
    end
  end

endmodule

// File: rtl/alu_iter.sv
// Handshaked ALU: logic/arith/shift ops complete in one cycle, multu/divu run
// on the iterative engine. Results are held in DONE until the consumer takes
// them.
module alu_iter
  import alu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       control,
  input  logic [WIDTH-1:0] inputA,
  input  logic [WIDTH-1:0] inputB,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] data,
  output logic [WIDTH-1:0] data_hi,
  output logic             zero,
  output logic             ovf,
  output logic             div0,
  output logic             bad_op
);

  state_t state;

  logic signed [WIDTH-1:0] a_s;
  logic signed [WIDTH-1:0] b_s;
  logic signed [WIDTH-1:0] sum_s;
  logic signed [WIDTH-1:0] diff_s;
  logic [SHW-1:0]          shamt;
  logic [WIDTH-1:0]        res_p0;
  logic                    ovf_p0;
  logic                    bad_p0;
  logic                    accept;
  logic                    is_md;
  logic                    div_by0;
  logic                    md_start;
  logic                    md_done;
  logic [WIDTH-1:0]        md_lo;
  logic [WIDTH-1:0]        md_hi;

  // Signed overflow of a + b = s: like-signed operands, differently-signed sum.
  function automatic logic add_ovf(input logic signed [WIDTH-1:0] x,
                                   input logic signed [WIDTH-1:0] y,
                                   input logic signed [WIDTH-1:0] s);
    return (x[WIDTH-1] == y[WIDTH-1]) && (s[WIDTH-1] != x[WIDTH-1]);
  endfunction

  // Signed overflow of x - y = d: unlike-signed operands, result sign flips.
  function automatic logic sub_ovf(input logic signed [WIDTH-1:0] x,
                                   input logic signed [WIDTH-1:0] y,
                                   input logic signed [WIDTH-1:0] d);
    return (x[WIDTH-1] != y[WIDTH-1]) && (d[WIDTH-1] != x[WIDTH-1]);
  endfunction

  assign a_s    = inputA;
  assign b_s    = inputB;
  assign sum_s  = a_s + b_s;
  assign diff_s = a_s - b_s;
  assign shamt  = inputB[SHW-1:0];

  assign in_ready = (state == IDLE);
  assign accept   = in_valid && in_ready;
  assign is_md    = (control == OP_MULTU) || (control == OP_DIVU);
  assign div_by0  = (control == OP_DIVU) && (inputB == '0);
  assign md_start = accept && is_md && !div_by0;

  // Single-cycle result and flags from the operands at the inputs.
  always_comb begin
    res_p0 = '0;
    ovf_p0 = 1'b0;
    bad_p0 = 1'b0;
    case (control)
      OP_AND:   res_p0 = inputA & inputB;
      OP_OR:    res_p0 = inputA | inputB;
      OP_XOR:   res_p0 = inputA ^ inputB;
      OP_NOR:   res_p0 = ~(inputA | inputB);
      OP_ADD: begin
        res_p0 = sum_s;
        ovf_p0 = add_ovf(a_s, b_s, sum_s);
      end
      OP_SUB: begin
        res_p0 = diff_s;
        ovf_p0 = sub_ovf(a_s, b_s, diff_s);
      end
      OP_SLT:   res_p0 = {{(WIDTH-1){1'b0}}, (a_s < b_s)};
      OP_SLTU:  res_p0 = {{(WIDTH-1){1'b0}}, (inputA < inputB)};
      OP_SLL:   res_p0 = inputA << shamt;
      OP_SRL:   res_p0 = inputA >> shamt;
      OP_SRA:   res_p0 = a_s >>> shamt;
      OP_MULTU: res_p0 = '0;
      OP_DIVU:  res_p0 = '0;
      default:  bad_p0 = 1'b1;
    endcase
  end

  alu_muldiv #(
    .WIDTH (WIDTH)
  ) u_muldiv (
    .clk    (clk),
    .reset  (reset),
    .start  (md_start),
    .op_div (control == OP_DIVU),
    .a      (inputA),
    .b      (inputB),
    .done   (md_done),
    .lo     (md_lo),
    .hi     (md_hi)
  );

  // Control FSM with registered result and flag outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      out_valid <= 1'b0;
      data      <= '0;
      data_hi   <= '0;
      zero      <= 1'b0;
      ovf       <= 1'b0;
      div0      <= 1'b0;
      bad_op    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            if (div_by0) begin
              state     <= DONE;
              out_valid <= 1'b1;
              data      <= '1;
              data_hi   <= inputA;
              zero      <= 1'b0;
              ovf       <= 1'b0;
              div0      <= 1'b1;
              bad_op    <= 1'b0;
            end else if (is_md) begin
              state <= ITER;
            end else begin
              state     <= DONE;
              out_valid <= 1'b1;
              data      <= res_p0;
              data_hi   <= '0;
              zero      <= (res_p0 == '0);
              ovf       <= ovf_p0;
              div0      <= 1'b0;
              bad_op    <= bad_p0;
            end
          end
        end
        ITER: begin
          if (md_done) begin
            state     <= DONE;
            out_valid <= 1'b1;
            data      <= md_lo;
            data_hi   <= md_hi;
            zero      <= (md_lo == '0);
            ovf       <= 1'b0;
            div0      <= 1'b0;
            bad_op    <= 1'b0;
          end
        end
        DONE: begin
          if (out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
          end
        end
        default: begin
          state     <= IDLE;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_iter.sv
// Directed bench for alu_iter (WIDTH=32): vector table plus stall and
// reset-abort sequences.
module tb_alu_iter;
  import alu_pkg::*;

  logic        clk;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  control;
  logic [31:0] inputA;
  logic [31:0] inputB;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] data;
  logic [31:0] data_hi;
  logic        zero;
  logic        ovf;
  logic        div0;
  logic        bad_op;

  int n_checks = 0;
  int n_fail   = 0;

  alu_iter #(.WIDTH(32)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .control   (control),
    .inputA    (inputA),
    .inputB    (inputB),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .data      (data),
    .data_hi   (data_hi),
    .zero      (zero),
    .ovf       (ovf),
    .div0      (div0),
    .bad_op    (bad_op)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] lo;
    logic [31:0] hi;
    logic        z;
    logic        o;
    logic        d0;
    logic        bad;
    int          lat;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic add_vec(input string name, input logic [3:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] lo, input logic [31:0] hi,
                         input logic z, input logic o, input logic d0, input logic bad,
                         input int lat);
    vec_t v;
    v.name = name; v.op = op; v.a = a; v.b = b; v.lo = lo; v.hi = hi;
    v.z = z; v.o = o; v.d0 = d0; v.bad = bad; v.lat = lat;
    vecs.push_back(v);
  endtask

  // Present a request at the next acceptance; returns with the accept edge past.
  task automatic issue(input string name, input logic [3:0] op, input logic [31:0] a,
                       input logic [31:0] b);
    int wait_cyc;
    wait_cyc = 0;
    while (!in_ready && wait_cyc < 100) begin
      @(posedge clk); #1;
      wait_cyc++;
    end
    if (!in_ready) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s ready_timeout: in_ready 0 after %0d cycles, required 1", name, wait_cyc);
    end
    control  = op;
    inputA   = a;
    inputB   = b;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  // Count cycles from the accept edge until out_valid is seen (bounded).
  task automatic wait_valid(input string name, output int lat);
    lat = 1;
    while (!out_valid && lat < 80) begin
      @(posedge clk); #1;
      lat++;
    end
    if (!out_valid) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s valid_timeout: out_valid 0 after %0d cycles, required 1", name, lat);
    end
  endtask

  initial begin
    int lat;
    int seen;

    reset     = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    control   = '0;
    inputA    = '0;
    inputB    = '0;

    add_vec("add_ovf",   OP_ADD,   32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000, 0, 0, 1, 0, 0, 1);
    add_vec("sub_zero",  OP_SUB,   32'd5,         32'd5,         32'd0,         0, 1, 0, 0, 0, 1);
    add_vec("slt_neg",   OP_SLT,   32'hFFFF_FFFF, 32'd1,         32'd1,         0, 0, 0, 0, 0, 1);
    add_vec("sltu_big",  OP_SLTU,  32'hFFFF_FFFF, 32'd1,         32'd0,         0, 1, 0, 0, 0, 1);
    add_vec("slt_pos",   OP_SLT,   32'd1,         32'hFFFF_FFFF, 32'd0,         0, 1, 0, 0, 0, 1);
    add_vec("multu_max", OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 32'hFFFF_FFFE, 0, 0, 0, 0, 33);
    add_vec("multu_7x6", OP_MULTU, 32'd7,         32'd6,         32'd42,        32'd0, 0, 0, 0, 0, 33);
    add_vec("multu_2e32",OP_MULTU, 32'h0001_0000, 32'h0001_0000, 32'd0,         32'd1, 1, 0, 0, 0, 33);
    add_vec("divu_100_7",OP_DIVU,  32'd100,       32'd7,         32'd14,        32'd2, 0, 0, 0, 0, 33);
    add_vec("divu_by1",  OP_DIVU,  32'hFFFF_FFFF, 32'd1,         32'hFFFF_FFFF, 32'd0, 0, 0, 0, 0, 33);
    add_vec("divu_3_10", OP_DIVU,  32'd3,         32'd10,        32'd0,         32'd3, 1, 0, 0, 0, 33);
    add_vec("divu_by0",  OP_DIVU,  32'd9,         32'd0,         32'hFFFF_FFFF, 32'd9, 0, 0, 1, 0, 1);
    add_vec("bad_1111",  4'b1111,  32'h1234_5678, 32'h1,         32'd0,         0, 1, 0, 0, 1, 1);
    add_vec("bad_1011",  4'b1011,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0,         0, 1, 0, 0, 1, 1);
    add_vec("and",       OP_AND,   32'hF0F0_F0F0, 32'h0FF0_0FF0, 32'h00F0_00F0, 0, 0, 0, 0, 0, 1);
    add_vec("or",        OP_OR,    32'h1234_0000, 32'h0000_5678, 32'h1234_5678, 0, 0, 0, 0, 0, 1);
    add_vec("xor",       OP_XOR,   32'hFFFF_0000, 32'hFF00_FF00, 32'h00FF_FF00, 0, 0, 0, 0, 0, 1);
    add_vec("nor",       OP_NOR,   32'hF000_0000, 32'h0000_000F, 32'h0FFF_FFF0, 0, 0, 0, 0, 0, 1);
    add_vec("sll_mask",  OP_SLL,   32'd1,         32'd33,        32'd2,         0, 0, 0, 0, 0, 1);
    add_vec("srl",       OP_SRL,   32'h8000_0000, 32'd4,         32'h0800_0000, 0, 0, 0, 0, 0, 1);
    add_vec("sra",       OP_SRA,   32'h8000_0000, 32'd4,         32'hF800_0000, 0, 0, 0, 0, 0, 1);
    add_vec("sub_ovf",   OP_SUB,   32'h8000_0000, 32'd1,         32'h7FFF_FFFF, 0, 0, 1, 0, 0, 1);
    add_vec("add_wrap",  OP_ADD,   32'hFFFF_FFFF, 32'd1,         32'd0,         0, 1, 0, 0, 0, 1);

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_in_ready",  64'(in_ready),  64'd1);
    chk("rst_data",      64'(data),      64'd0);
    chk("rst_flags",     64'({zero, ovf, div0, bad_op}), 64'd0);

    // Table-driven vectors
    foreach (vecs[i]) begin
      issue(vecs[i].name, vecs[i].op, vecs[i].a, vecs[i].b);
      wait_valid(vecs[i].name, lat);
      chk({vecs[i].name, "_lat"},  64'(lat),     64'(vecs[i].lat));
      chk({vecs[i].name, "_lo"},   64'(data),    64'(vecs[i].lo));
      chk({vecs[i].name, "_hi"},   64'(data_hi), 64'(vecs[i].hi));
      chk({vecs[i].name, "_zero"}, 64'(zero),    64'(vecs[i].z));
      chk({vecs[i].name, "_ovf"},  64'(ovf),     64'(vecs[i].o));
      chk({vecs[i].name, "_div0"}, 64'(div0),    64'(vecs[i].d0));
      chk({vecs[i].name, "_bad"},  64'(bad_op),  64'(vecs[i].bad));
      @(posedge clk); #1;
      chk({vecs[i].name, "_drain_valid"}, 64'(out_valid), 64'd0);
      chk({vecs[i].name, "_drain_ready"}, 64'(in_ready),  64'd1);
    end

    // Hold a result in DONE for 10 cycles while new requests are offered
    out_ready = 1'b0;
    issue("stall", OP_ADD, 32'd2, 32'd3);
    wait_valid("stall", lat);
    chk("stall_lat", 64'(lat), 64'd1);
    for (int k = 0; k < 10; k++) begin
      control  = OP_SUB;
      inputA   = 32'd100;
      inputB   = 32'd1;
      in_valid = 1'b1;
      @(posedge clk); #1;
      chk("stall_data",     64'(data),      64'd5);
      chk("stall_valid",    64'(out_valid), 64'd1);
      chk("stall_in_ready", 64'(in_ready),  64'd0);
      chk("stall_hi",       64'(data_hi),   64'd0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk("stall_release_valid", 64'(out_valid), 64'd0);
    chk("stall_release_ready", 64'(in_ready),  64'd1);
    chk("stall_release_data",  64'(data),      64'd5);

    // Reset five cycles into a multiply aborts it
    issue("abort", OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    repeat (4) @(posedge clk);
    #1;
    reset = 1'b1;
    out_ready = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    chk("abort_valid",   64'(out_valid), 64'd0);
    chk("abort_ready",   64'(in_ready),  64'd1);
    chk("abort_data",    64'(data),      64'd0);
    chk("abort_data_hi", 64'(data_hi),   64'd0);
    chk("abort_flags",   64'({zero, ovf, div0, bad_op}), 64'd0);
    seen = 0;
    for (int k = 0; k < 40; k++) begin
      @(posedge clk); #1;
      if (out_valid) seen++;
    end
    chk("abort_no_result", 64'(seen), 64'd0);

    // Operation after abort behaves normally
    issue("post_abort", 4'b1111, 32'h5, 32'h5);
    wait_valid("post_abort", lat);
    chk("post_abort_lat",  64'(lat),    64'd1);
    chk("post_abort_bad",  64'(bad_op), 64'd1);
    chk("post_abort_data", 64'(data),   64'd0);
    @(posedge clk); #1;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_iter.md
ALU_ITER -- requirements
Module: alu_iter

Interface
REQ-001 SHALL have parameter WIDTH, default 32, operand/result width in bits (legal: 8..64, power of 2).
REQ-002 SHALL have parameter SHW, default $clog2(WIDTH), shift-amount width taken from inputB[SHW-1:0].
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 in_valid  input  1  operation request present.
REQ-006 in_ready  output  1  block accepts a request this cycle.
REQ-007 control  input  4  opcode (REQ-014).
REQ-008 inputA  input  WIDTH  operand A / rs data.
REQ-009 inputB  input  WIDTH  operand B / mux result.
REQ-010 out_valid  output  1  result registers hold a valid result.
REQ-011 out_ready  input  1  consumer takes the result this cycle.
REQ-012 data  output  WIDTH  result (product low / quotient).
REQ-013 data_hi, zero, ovf, div0, bad_op  outputs  WIDTH,1,1,1,1  product high / remainder; data==0; signed add/sub overflow; divide by zero; undefined opcode.

Function
REQ-014 Opcodes SHALL be: 0000 and, 0001 or, 0010 add, 0011 xor, 0100 nor, 0110 sub, 0111 slt (signed), 0101 sltu, 1000 sll, 1001 srl, 1010 sra, 1100 multu, 1101 divu; all others undefined.
REQ-015 FSM states SHALL be IDLE, ITER, DONE; in_ready = 1 only in IDLE.
REQ-016 Request SHALL be accepted on a cycle with in_valid && in_ready; operands and opcode captured into internal registers that cycle.
REQ-017 Single-cycle opcodes: IDLE -> DONE; result and flags registered at accept edge; out_valid = 1 on the following cycle (latency 1).
REQ-018 multu/divu: IDLE -> ITER; iterative engine runs exactly WIDTH cycles, then -> DONE; out_valid rises WIDTH+1 cycles after accept.
REQ-019 multu SHALL be unsigned shift-add, one bit per cycle; {data_hi,data} = 2*WIDTH-bit product.
REQ-020 divu SHALL be unsigned restoring, one bit per cycle; data = quotient, data_hi = remainder.
REQ-021 divu with inputB == 0 SHALL skip ITER (latency 1), data = all ones, data_hi = inputA, div0 = 1.
REQ-022 In DONE, data/data_hi/flags SHALL stay stable until out_ready = 1; then -> IDLE next cycle, out_valid = 0 (max throughput 1 result / 2 cycles).
REQ-023 slt/sltu SHALL produce 0 or 1 zero-extended to WIDTH; shifts use only inputB[SHW-1:0]; sra sign-fills.
REQ-024 ovf SHALL be set only for add/sub on signed overflow, 0 otherwise; add/sub result wraps modulo 2^WIDTH.
REQ-025 zero SHALL be registered with data and equal (data == 0); data_hi for single-cycle ops = 0.
REQ-026 Undefined opcode: data = 0, bad_op = 1, latency 1; no X ever driven on outputs.
REQ-027 in_valid while not in IDLE SHALL be ignored (no capture, no state change).

Reset
REQ-028 reset SHALL force state IDLE, out_valid 0, data 0, data_hi 0, zero 0, ovf 0, div0 0, bad_op 0, iteration counter 0, on the next rising edge.
REQ-029 reset during ITER or DONE SHALL abort the operation, discard the result; in_ready = 1 the cycle after reset deasserts.
REQ-030 reset SHALL dominate a simultaneous accept or out_ready.

Structure
REQ-031 Package alu_pkg SHALL hold the 4-bit opcode constants and the FSM state encoding.
REQ-032 The iterative multiply/divide datapath (accumulator, shift register, counter) SHALL be sub-module alu_muldiv, started by a one-cycle start pulse, returning done, lo, hi.
REQ-033 Single-cycle operations SHALL be combinational logic in alu_iter feeding the result registers.

Verification (WIDTH=32)
REQ-034 add 0x7FFFFFFF + 0x00000001, out_ready=1 -> out_valid next cycle, data 0x80000000, ovf 1, zero 0.
REQ-035 sub 5 - 5 -> data 0, zero 1; slt 0xFFFFFFFF vs 1 -> data 1; sltu same -> data 0.
REQ-036 multu 0xFFFFFFFF * 0xFFFFFFFF -> out_valid 33 cycles after accept, data_hi 0xFFFFFFFE, data 0x00000001.
REQ-037 divu 100 / 7 -> data 14, data_hi 2 at 33 cycles; divu 9 / 0 -> latency 1, data 0xFFFFFFFF, data_hi 9, div0 1.
REQ-038 out_ready held 0 for 10 cycles in DONE -> outputs stable, in_ready 0, new in_valid ignored; out_ready 1 -> IDLE next cycle.
REQ-039 reset asserted 5 cycles into multu -> next cycle all outputs 0, in_ready 1; control 1111 -> bad_op 1, data 0.
